// File: rtl/battleship_if.sv
// rtl/battleship_if.sv - control, read-port and status bundle for battleship_core
interface battleship_if #(
  parameter int BOARD_N   = 5,
  parameter int MAX_SHIPS = 5
);
  localparam int CW = (BOARD_N > 1) ? $clog2(BOARD_N) : 1;
  localparam int SW = $clog2(MAX_SHIPS + 1);

  logic          move_up;
  logic          move_down;
  logic          move_left;
  logic          move_right;
  logic [SW-1:0] ships_req;
  logic          confirm_amount;
  logic          confirm_place;
  logic          confirm_attack;
  logic          rd_board;
  logic [CW-1:0] rd_i;
  logic [CW-1:0] rd_j;
  logic [1:0]    rd_cell;
  logic [CW-1:0] i_actual;
  logic [CW-1:0] j_actual;
  logic          decision_State;
  logic          colocation_ships_State;
  logic          setup_State;
  logic          player_turn_State;
  logic          pc_turn_State;
  logic          is_victory_State;
  logic          is_defeat_State;
  logic [SW-1:0] ships_defined;
  logic [SW-1:0] ships_left_player;
  logic [SW-1:0] ships_left_pc;
  logic          placement_error;

  modport master (
    output move_up, move_down, move_left, move_right, ships_req,
    output confirm_amount, confirm_place, confirm_attack,
    output rd_board, rd_i, rd_j,
    input  rd_cell, i_actual, j_actual,
    input  decision_State, colocation_ships_State, setup_State, player_turn_State,
    input  pc_turn_State, is_victory_State, is_defeat_State,
    input  ships_defined, ships_left_player, ships_left_pc, placement_error
  );

  modport slave (
    input  move_up, move_down, move_left, move_right, ships_req,
    input  confirm_amount, confirm_place, confirm_attack,
    input  rd_board, rd_i, rd_j,
    output rd_cell, i_actual, j_actual,
    output decision_State, colocation_ships_State, setup_State, player_turn_State,
    output pc_turn_State, is_victory_State, is_defeat_State,
    output ships_defined, ships_left_player, ships_left_pc, placement_error
  );
endinterface

// File: rtl/battleship_core.sv
// rtl/battleship_core.sv - single-player battleship game engine with LFSR-driven opponent
module battleship_core #(
  parameter int          BOARD_N     = 5,
  parameter int          MAX_SHIPS   = 5,
  parameter int          CURSOR_WRAP = 0,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst,
  battleship_if.slave bus
);
  localparam int CW  = (BOARD_N > 1) ? $clog2(BOARD_N) : 1;
  localparam int SW  = $clog2(MAX_SHIPS + 1);
  localparam int CWP = CW + 1;
  localparam logic [CWP-1:0] BN_L = CWP'(BOARD_N);
  localparam logic [CW-1:0]  EDGE = CW'(BOARD_N - 1);
  localparam logic [SW-1:0]  MAX_L = SW'(MAX_SHIPS);

  typedef enum logic [2:0] {
    S_DECISION, S_PLACE, S_SETUP, S_PLAYER, S_PC, S_VICTORY, S_DEFEAT
  } state_t;

  state_t        state, state_n;
  logic [15:0]   lfsr;
  logic [1:0]    player_b [BOARD_N][BOARD_N];
  logic [1:0]    pc_b     [BOARD_N][BOARD_N];
  logic [CW-1:0] cur_i, cur_j, cur_i_n, cur_j_n;
  logic [SW-1:0] placed_cnt, ships_def, left_pl, left_pc, ships_clamped;
  logic          err_q, err_n;

  logic [CW-1:0] ri, rj;
  logic          cand_ok;
  logic [1:0]    pl_cand, pc_cand, pl_cur, pc_cur;

  logic          pl_we, pc_we, def_we, placed_inc, clear_all;
  logic          left_pl_inc, left_pl_dec, left_pc_inc, left_pc_dec;
  logic [CW-1:0] pl_wi, pl_wj, pc_wi, pc_wj;
  logic [1:0]    pl_wd, pc_wd;

  function automatic logic [CW-1:0] step_dec(input logic [CW-1:0] v);
    if (v != '0) return v - CW'(1);
    return (CURSOR_WRAP != 0) ? EDGE : v;
  endfunction

  function automatic logic [CW-1:0] step_inc(input logic [CW-1:0] v);
    if (v != EDGE) return v + CW'(1);
    return (CURSOR_WRAP != 0) ? '0 : v;
  endfunction

  // Random candidates come straight from the low LFSR bits; out-of-board picks read as "unusable".
  assign ri      = lfsr[CW-1:0];
  assign rj      = lfsr[2*CW-1:CW];
  assign cand_ok = ({1'b0, ri} < BN_L) && ({1'b0, rj} < BN_L);
  assign pl_cand = cand_ok ? player_b[ri][rj] : 2'b11;
  assign pc_cand = cand_ok ? pc_b[ri][rj] : 2'b11;
  assign pl_cur  = player_b[cur_i][cur_j];
  assign pc_cur  = pc_b[cur_i][cur_j];

  always_comb begin
    ships_clamped = bus.ships_req;
    if (bus.ships_req == '0)
      ships_clamped = SW'(1);
    else if (bus.ships_req > MAX_L)
      ships_clamped = MAX_L;
  end

  always_comb begin
    cur_i_n = cur_i;
    cur_j_n = cur_j;
    if (state == S_PLACE || state == S_PLAYER) begin
      if (bus.move_up)         cur_i_n = step_dec(cur_i);
      else if (bus.move_down)  cur_i_n = step_inc(cur_i);
      else if (bus.move_left)  cur_j_n = step_dec(cur_j);
      else if (bus.move_right) cur_j_n = step_inc(cur_j);
    end
  end

  always_comb begin
    state_n     = state;
    err_n       = 1'b0;
    pl_we       = 1'b0;
    pc_we       = 1'b0;
    pl_wi       = cur_i;
    pl_wj       = cur_j;
    pl_wd       = 2'b00;
    pc_wi       = cur_i;
    pc_wj       = cur_j;
    pc_wd       = 2'b00;
    def_we      = 1'b0;
    placed_inc  = 1'b0;
    clear_all   = 1'b0;
    left_pl_inc = 1'b0;
    left_pl_dec = 1'b0;
    left_pc_inc = 1'b0;
    left_pc_dec = 1'b0;
    case (state)
      S_DECISION: begin
        if (bus.confirm_amount) begin
          def_we  = 1'b1;
          state_n = S_PLACE;
        end
      end
      S_PLACE: begin
        if (bus.confirm_place) begin
          if (pl_cur == 2'b00) begin
            pl_we       = 1'b1;
            pl_wd       = 2'b01;
            placed_inc  = 1'b1;
            left_pl_inc = 1'b1;
            if (placed_cnt + SW'(1) == ships_def) state_n = S_SETUP;
          end else begin
            err_n = 1'b1;
          end
        end
      end
      S_SETUP: begin
        if (pc_cand == 2'b00) begin
          pc_we       = 1'b1;
          pc_wi       = ri;
          pc_wj       = rj;
          pc_wd       = 2'b01;
          left_pc_inc = 1'b1;
          if (left_pc + SW'(1) == ships_def) state_n = S_PLAYER;
        end
      end
      S_PLAYER: begin
        if (bus.confirm_attack) begin
          if (pc_cur[1]) begin
            err_n = 1'b1;
          end else begin
            // Setting bit 1 turns ship into hit and empty into miss in one step.
            pc_we       = 1'b1;
            pc_wd       = {1'b1, pc_cur[0]};
            left_pc_dec = pc_cur[0];
            state_n     = (pc_cur[0] && left_pc == SW'(1)) ? S_VICTORY : S_PC;
          end
        end
      end
      S_PC: begin
        if (!pl_cand[1]) begin
          pl_we       = 1'b1;
          pl_wi       = ri;
          pl_wj       = rj;
          pl_wd       = {1'b1, pl_cand[0]};
          left_pl_dec = pl_cand[0];
          state_n     = (pl_cand[0] && left_pl == SW'(1)) ? S_DEFEAT : S_PLAYER;
        end
      end
      S_VICTORY, S_DEFEAT: begin
        if (bus.confirm_amount) begin
          clear_all = 1'b1;
          state_n   = S_DECISION;
        end
      end
      default: state_n = S_DECISION;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= S_DECISION;
    else     state <= state_n;
  end

  always_ff @(posedge clk) begin
    if (rst) lfsr <= LFSR_SEED;
    else     lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  end

  always_ff @(posedge clk) begin
    if (rst) err_q <= 1'b0;
    else     err_q <= err_n;
  end

  always_ff @(posedge clk) begin
    if (rst || clear_all) begin
      for (int a = 0; a < BOARD_N; a++) begin
        for (int b = 0; b < BOARD_N; b++) begin
          player_b[a][b] <= 2'b00;
          pc_b[a][b]     <= 2'b00;
        end
      end
      cur_i      <= '0;
      cur_j      <= '0;
      placed_cnt <= '0;
      ships_def  <= '0;
      left_pl    <= '0;
      left_pc    <= '0;
    end else begin
      cur_i <= cur_i_n;
      cur_j <= cur_j_n;
      if (pl_we)      player_b[pl_wi][pl_wj] <= pl_wd;
      if (pc_we)      pc_b[pc_wi][pc_wj]     <= pc_wd;
      if (def_we)     ships_def  <= ships_clamped;
      if (placed_inc) placed_cnt <= placed_cnt + SW'(1);
      if (left_pl_inc)      left_pl <= left_pl + SW'(1);
      else if (left_pl_dec) left_pl <= left_pl - SW'(1);
      if (left_pc_inc)      left_pc <= left_pc + SW'(1);
      else if (left_pc_dec) left_pc <= left_pc - SW'(1);
    end
  end

  always_comb begin
    bus.rd_cell = 2'b00;
    if (({1'b0, bus.rd_i} < BN_L) && ({1'b0, bus.rd_j} < BN_L))
      bus.rd_cell = bus.rd_board ? pc_b[bus.rd_i][bus.rd_j] : player_b[bus.rd_i][bus.rd_j];
  end

  assign bus.i_actual               = cur_i;
  assign bus.j_actual               = cur_j;
  assign bus.decision_State         = (state == S_DECISION);
  assign bus.colocation_ships_State = (state == S_PLACE);
  assign bus.setup_State            = (state == S_SETUP);
  assign bus.player_turn_State      = (state == S_PLAYER);
  assign bus.pc_turn_State          = (state == S_PC);
  assign bus.is_victory_State       = (state == S_VICTORY);
  assign bus.is_defeat_State        = (state == S_DEFEAT);
  assign bus.ships_defined          = ships_def;
  assign bus.ships_left_player      = left_pl;
  assign bus.ships_left_pc          = left_pc;
  assign bus.placement_error        = err_q;
endmodule
